ask4_sym_slicer: RTL and testbench



---
 rtl/ask4_pkg.sv | 24 ++
 rtl/ask4_decide.sv | 88 ++++++++
 rtl/ask4_sym_slicer.sv | 155 +++++++++++++++
 tb/tb_ask4_sym_slicer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ask4_pkg.sv
// Shared definitions for the 4-ASK symbol slicer: widths, Gray codes, FSM states, limits.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package ask4_pkg;

    localparam int WIDTH = 18;

    // Gray mapping of the four amplitude levels
    localparam logic [1:0] G_M3 = 2'b00;
    localparam logic [1:0] G_M1 = 2'b01;
    localparam logic [1:0] G_P1 = 2'b11;
    localparam logic [1:0] G_P3 = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DUMP  = 2'd2
    } state_t;

    // Symmetric 1s17 saturation limits, so -2^17 is never produced
    localparam int SAT_MAX = (1 << (WIDTH - 1)) - 1;
    localparam int SAT_MIN = -SAT_MAX;

endpackage

// File: rtl/ask4_decide.sv
// Registered 4-ASK slicer: Gray decision, saturated decision error and |y| from one captured symbol.
// Latency: 1 sys_clk from cap/ysym to dec/err/y_abs/valid.
// Backpressure: none; every cap produces one valid strobe.
module ask4_decide #(
    parameter int WIDTH = ask4_pkg::WIDTH
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    cap,
    input  logic signed [WIDTH-1:0] ysym,
    input  logic signed [WIDTH-1:0] thr,
    output logic [1:0]              dec,
    output logic signed [WIDTH-1:0] err,
    output logic [WIDTH-1:0]        y_abs,
    output logic                    valid
);
    import ask4_pkg::*;

    localparam int XW = WIDTH + 2;
    localparam logic signed [XW-1:0] ERR_HI = XW'(SAT_MAX);
    localparam logic signed [XW-1:0] ERR_LO = XW'(SAT_MIN);
    localparam logic [WIDTH-1:0]     Y_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [XW-1:0]    y_x;
    logic signed [XW-1:0]    thr_x;
    logic signed [XW-1:0]    b_x;
    logic signed [XW-1:0]    b3_x;
    logic signed [XW-1:0]    level;
    logic signed [XW-1:0]    diff;
    logic [1:0]              dec_nxt;
    logic signed [WIDTH-1:0] err_nxt;
    logic [WIDTH-1:0]        abs_nxt;

    // Levels are +-b and +-3b with b = thr/2; 3b can exceed 1s17, hence the two guard bits
    always_comb begin
        y_x   = XW'(ysym);
        thr_x = XW'(thr);
        b_x   = thr_x >>> 1;
        b3_x  = thr_x + b_x;

        dec_nxt = G_M3;
        level   = -b3_x;
        if (y_x >= thr_x) begin
            dec_nxt = G_P3;
            level   = b3_x;
        end else if (!ysym[WIDTH-1]) begin
            dec_nxt = G_P1;
            level   = b_x;
        end else if (y_x >= -thr_x) begin
            dec_nxt = G_M1;
            level   = -b_x;
        end

        diff = y_x - level;
        if (diff > ERR_HI) begin
            err_nxt = WIDTH'(ERR_HI);
        end else if (diff < ERR_LO) begin
            err_nxt = WIDTH'(ERR_LO);
        end else begin
            err_nxt = WIDTH'(diff);
        end

        if (!ysym[WIDTH-1]) begin
            abs_nxt = ysym;
        end else if (ysym == Y_MOST_NEG) begin
            abs_nxt = WIDTH'(SAT_MAX);
        end else begin
            abs_nxt = -ysym;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            dec   <= '0;
            err   <= '0;
            y_abs <= '0;
            valid <= 1'b0;
        end else begin
            valid <= cap;
            if (cap) begin
                dec   <= dec_nxt;
                err   <= err_nxt;
                y_abs <= abs_nxt;
            end
        end
    end

endmodule

// File: rtl/ask4_sym_slicer.sv
// Symbol-rate 4-ASK slicer: phase-selected decimation, decision, block means of |y| and error power.
// Latency: dec_valid 2 sys_clk after the capture strobe; acc_done 2 sys_clk after the block's last dec_valid.
// Backpressure: none; strobe driven. SLICER_FIXED_THR_EN holds the threshold at THR_INIT.
module ask4_sym_slicer #(
    parameter int                          WIDTH        = ask4_pkg::WIDTH,
    parameter int                          SPS          = 4,
    parameter int                          PH_W         = 2,
    parameter int                          ACC_LEN_LOG2 = 10,
    parameter logic signed [WIDTH-1:0]     THR_INIT     = 18'sd65536
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic                    sym_clk_en,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic [PH_W-1:0]         sym_phase,
    output logic [1:0]              dec_out,
    output logic                    dec_valid,
    output logic signed [WIDTH-1:0] err_out,
    output logic signed [WIDTH-1:0] thr_out,
    output logic [WIDTH-1:0]        err_pwr_out,
    output logic                    acc_done
);
    import ask4_pkg::*;

    localparam int SUM_W = WIDTH + ACC_LEN_LOG2;
    localparam int PW    = 2 * WIDTH;

    state_t                  state;
    logic [PH_W-1:0]         ph;
    logic                    ph_hit;
    logic                    cap;
    logic                    cap_q;
    logic signed [WIDTH-1:0] ysym;
    logic [WIDTH-1:0]        y_abs;
    logic [ACC_LEN_LOG2-1:0] sym_cnt;
    logic [SUM_W-1:0]        sum_esq;
    logic [WIDTH-1:0]        pwr_mean;
    logic [ACC_LEN_LOG2-1:0] pwr_frac_unused;
    logic signed [PW-1:0]    prod;
    logic [WIDTH-1:0]        esq;
    logic                    prod_sign_unused;
    logic [WIDTH-2:0]        prod_lo_unused;

    // sym_clk_en restarts the sample index at 0, so the symbol's first sample is judged against phase 0
    always_comb begin
        ph_hit = sym_clk_en ? (sym_phase == '0) : (ph == sym_phase);
        cap    = sam_clk_en && ph_hit && ((state != IDLE) || sym_clk_en);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ph <= '0;
        end else if (sam_clk_en) begin
            if (sym_clk_en) begin
                ph <= PH_W'(1);
            end else if (ph == PH_W'(SPS - 1)) begin
                ph <= '0;
            end else begin
                ph <= ph + PH_W'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ysym  <= '0;
            cap_q <= 1'b0;
        end else begin
            cap_q <= cap;
            if (cap) begin
                ysym <= y_in;
            end
        end
    end

    ask4_decide #(
        .WIDTH (WIDTH)
    ) u_decide (
        .sys_clk (sys_clk),
        .reset   (reset),
        .cap     (cap_q),
        .ysym    (ysym),
        .thr     (thr_out),
        .dec     (dec_out),
        .err     (err_out),
        .y_abs   (y_abs),
        .valid   (dec_valid)
    );

    // err^2 is 2s34; bits [34:17] give the unsigned 1s17 power sample
    assign prod = PW'(err_out) * PW'(err_out);
    assign {prod_sign_unused, esq, prod_lo_unused} = prod;
    assign {pwr_mean, pwr_frac_unused} = sum_esq;

`ifdef SLICER_FIXED_THR_EN
    logic [WIDTH-1:0] y_abs_unused;
    assign y_abs_unused = y_abs;
`else
    logic [SUM_W-1:0]        sum_abs;
    logic [WIDTH-1:0]        thr_mean;
    logic [ACC_LEN_LOG2-1:0] abs_frac_unused;
    assign {thr_mean, abs_frac_unused} = sum_abs;
`endif

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state       <= IDLE;
            sym_cnt     <= '0;
            sum_esq     <= '0;
`ifndef SLICER_FIXED_THR_EN
            sum_abs     <= '0;
`endif
            thr_out     <= THR_INIT;
            err_pwr_out <= '0;
            acc_done    <= 1'b0;
        end else begin
            acc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (sam_clk_en && sym_clk_en) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (dec_valid) begin
                        sum_esq <= sum_esq + SUM_W'(esq);
`ifndef SLICER_FIXED_THR_EN
                        sum_abs <= sum_abs + SUM_W'(y_abs);
`endif
                        sym_cnt <= sym_cnt + 1'b1;
                        if (&sym_cnt) begin
                            state <= DUMP;
                        end
                    end
                end
                DUMP: begin
`ifndef SLICER_FIXED_THR_EN
                    thr_out <= signed'(thr_mean);
                    sum_abs <= '0;
`endif
                    err_pwr_out <= pwr_mean;
                    acc_done    <= 1'b1;
                    sum_esq     <= '0;
                    sym_cnt     <= '0;
                    state       <= ACCUM;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ask4_sym_slicer.sv
// Self-checking bench for ask4_sym_slicer: table vectors, hand sequences and a randomized run vs a reference model.
module tb_ask4_sym_slicer;

    localparam int WIDTH    = 18;
    localparam int SPS      = 4;
    localparam int NLOG2    = 2;
    localparam int NBLK     = 1 << NLOG2;
    localparam int THR_INIT = 65536;
    localparam int SATV     = 131071;
`ifdef SLICER_FIXED_THR_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic                    sys_clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    sam_clk_en = 1'b0;
    logic                    sym_clk_en = 1'b0;
    logic signed [WIDTH-1:0] y_in = '0;
    logic [1:0]              sym_phase = '0;
    logic [1:0]              dec_out;
    logic                    dec_valid;
    logic signed [WIDTH-1:0] err_out;
    logic signed [WIDTH-1:0] thr_out;
    logic [WIDTH-1:0]        err_pwr_out;
    logic                    acc_done;

    always #5 sys_clk = ~sys_clk;

    ask4_sym_slicer #(
        .WIDTH        (WIDTH),
        .SPS          (SPS),
        .PH_W         (2),
        .ACC_LEN_LOG2 (NLOG2),
        .THR_INIT     (18'sd65536)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .sam_clk_en  (sam_clk_en),
        .sym_clk_en  (sym_clk_en),
        .y_in        (y_in),
        .sym_phase   (sym_phase),
        .dec_out     (dec_out),
        .dec_valid   (dec_valid),
        .err_out     (err_out),
        .thr_out     (thr_out),
        .err_pwr_out (err_pwr_out),
        .acc_done    (acc_done)
    );

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {int dec; int err; int cyc;} dexp_t;
    typedef struct {int thr; int pwr;} aexp_t;
    typedef struct {int y; int dec; int err;} vec_t;

    dexp_t dq[$];
    aexp_t aq[$];
    int    dec_seen = 0;
    int    acc_seen = 0;
    int    last_dec = 0;
    int    last_err = 0;

    // Reference model state
    int    m_idx = 0;
    bit    m_started = 1'b0;
    int    m_thr = THR_INIT;
    int    m_n = 0;
    longint m_sabs = 0;
    longint m_sesq = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_idx = 0; m_started = 1'b0; m_thr = THR_INIT;
        m_n = 0; m_sabs = 0; m_sesq = 0;
        dq.delete(); aq.delete();
    endfunction

    // Spec-level model: symbol index, phase select, nearest-level slicing on plain integers
    function automatic void model_sample(int y, bit sym, int phs);
        int b, lvl, d, e, a;
        dexp_t de;
        aexp_t ae;
        if (sym) begin
            m_started = 1'b1;
            m_idx = 0;
        end else begin
            m_idx = (m_idx + 1) % SPS;
        end
        if (!m_started || m_idx != phs) return;
        b = m_thr >>> 1;
        if (y >= m_thr)       begin d = 2; lvl = m_thr + b; end
        else if (y >= 0)      begin d = 3; lvl = b; end
        else if (y >= -m_thr) begin d = 1; lvl = -b; end
        else                  begin d = 0; lvl = -(m_thr + b); end
        e = y - lvl;
        if (e > SATV) e = SATV;
        if (e < -SATV) e = -SATV;
        a = (y < 0) ? -y : y;
        if (a > SATV) a = SATV;
        de.dec = d; de.err = e; de.cyc = cyc + 2;
        dq.push_back(de);
        m_sabs += a;
        m_sesq += (longint'(e) * e) >>> 17;
        m_n++;
        if (m_n == NBLK) begin
            ae.thr = FIXED ? THR_INIT : int'(m_sabs / NBLK);
            ae.pwr = int'(m_sesq / NBLK);
            aq.push_back(ae);
            m_thr = ae.thr;
            m_n = 0; m_sabs = 0; m_sesq = 0;
        end
    endfunction

    task automatic monitor();
        dexp_t de;
        aexp_t ae;
        forever begin
            @(negedge sys_clk);
            if (!reset) begin
                if (dec_valid) begin
                    dec_seen++;
                    last_dec = int'(dec_out);
                    last_err = int'(err_out);
                    if (dq.size() == 0) begin
                        check("unexpected_dec_valid", 1, 0);
                    end else begin
                        de = dq.pop_front();
                        check("dec_out", dec_out, de.dec);
                        check("err_out", err_out, de.err);
                        check("dec_latency", cyc, de.cyc);
                    end
                end
                if (acc_done) begin
                    acc_seen++;
                    if (aq.size() == 0) begin
                        check("unexpected_acc_done", 1, 0);
                    end else begin
                        ae = aq.pop_front();
                        check("thr_out", thr_out, ae.thr);
                        check("err_pwr_out", err_pwr_out, ae.pwr);
                    end
                end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        reset = 1'b1; sam_clk_en = 1'b0; sym_clk_en = 1'b0; y_in = '0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        check("rst_dec_out", dec_out, 0);
        check("rst_dec_valid", dec_valid, 0);
        check("rst_err_out", err_out, 0);
        check("rst_acc_done", acc_done, 0);
        check("rst_err_pwr_out", err_pwr_out, 0);
        check("rst_thr_out", thr_out, THR_INIT);
        reset = 1'b0;
    endtask

    task automatic send_sample(input int y, input bit sym, input int gap);
        @(negedge sys_clk);
        y_in = WIDTH'(y);
        sam_clk_en = 1'b1;
        sym_clk_en = sym;
        model_sample(y, sym, int'(sym_phase));
        @(negedge sys_clk);
        sam_clk_en = 1'b0;
        sym_clk_en = 1'b0;
        repeat (gap) @(negedge sys_clk);
    endtask

    task automatic send_symbol(input int y);
        for (int k = 0; k < SPS; k++) send_sample(y, k == 0, 2);
    endtask

    int   d0;
    int   a0;
    int   yv;
    vec_t tv[5];

    initial begin
        tv[0] = '{98304, 2, 0};
        tv[1] = '{40000, 3, 7232};
        tv[2] = '{65536, 2, -32768};
        tv[3] = '{0, 3, -32768};
        tv[4] = '{-131072, 0, -32768};

        fork
            monitor();
        join_none

        // Single symbols at the reset threshold
        sym_phase = 2'd0;
        for (int i = 0; i < 5; i++) begin
            apply_reset();
            d0 = dec_seen;
            send_symbol(tv[i].y);
            check("tbl_nvalid", dec_seen - d0, 1);
            check("tbl_dec", last_dec, tv[i].dec);
            check("tbl_err", last_err, tv[i].err);
        end

        // One measurement block, then a decision against the new threshold
        apply_reset();
        a0 = acc_seen;
        repeat (NBLK) send_symbol(98304);
        check("blk_acc_count", acc_seen - a0, 1);
        check("blk_thr", thr_out, FIXED ? 65536 : 98304);
        check("blk_pwr", err_pwr_out, 0);
        send_symbol(98304);
        check("blk_next_dec", last_dec, 2);
        check("blk_next_err", last_err, FIXED ? 0 : -49152);

        // Phase select 2 on a ramp: only the third sample of each symbol is decided
        apply_reset();
        sym_phase = 2'd2;
        d0 = dec_seen;
        for (int s = 0; s < 3; s++)
            for (int k = 0; k < SPS; k++) send_sample(k * 1000, k == 0, 2);
        check("ph_nvalid", dec_seen - d0, 3);
        check("ph_dec", last_dec, 3);
        check("ph_err", last_err, 2000 - 32768);

        // Reset mid-block discards the partial sums and symbol count
        apply_reset();
        sym_phase = 2'd0;
        repeat (2) send_symbol(120000);
        apply_reset();
        a0 = acc_seen;
        repeat (NBLK - 1) send_symbol(30000);
        check("mid_acc_early", acc_seen - a0, 0);
        send_symbol(30000);
        check("mid_acc_done", acc_seen - a0, 1);
        check("mid_pending_acc", aq.size(), 0);

        // Randomized run; idle samples before the first symbol strobe must not be captured
        apply_reset();
        d0 = dec_seen;
        send_sample(5000, 1'b0, 2);
        send_sample(-5000, 1'b0, 2);
        check("idle_no_capture", dec_seen - d0, 0);
        for (int s = 0; s < 40; s++) begin
            for (int k = 0; k < SPS; k++) begin
                sym_phase = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       yv = -131072;
                    1:       yv = 131071;
                    default: yv = int'($urandom_range(0, 262143)) - 131072;
                endcase
                send_sample(yv, k == 0, int'($urandom_range(2, 5)));
            end
        end
        repeat (10) @(negedge sys_clk);
        check("rand_pending_dec", dq.size(), 0);
        check("rand_pending_acc", aq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", nchk);
        $fatal(1, "watchdog");
    end

endmodule
